// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational ALU between the integer
// pipeline (port 0) and the approximate-accumulate engine (port 1).
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [OP_W-1:0]   req_op0,
  input  logic [OP_W-1:0]   req_op1,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_b1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [OP_W-1:0]   alu_decode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_x,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy,
  output logic [CNT_W-1:0]  ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  state_t state_next;
  logic   ptr;
  logic   grant_q;
  logic   grant_sel;
  logic   handshake;
  logic   rsp_done;

  // The pointer only breaks ties; a lone requester always wins.
  always_comb begin
    if (req_valid == 2'b11) grant_sel = ptr;
    else                    grant_sel = req_valid[1];
  end

  assign handshake = (state == IDLE) && (req_valid != 2'b00);
  assign rsp_done  = (state == RESP) && rsp_ready[grant_q];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (handshake) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    if (handshake) req_ready[grant_sel] = 1'b1;
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_decode <= '0;
      alu_a      <= '0;
      alu_x      <= '0;
      rsp_data   <= '0;
      rsp_valid  <= 2'b00;
      ops_done   <= '0;
      ptr        <= 1'b0;
      grant_q    <= 1'b0;
    end else begin
      if (handshake) begin
        alu_decode <= grant_sel ? req_op1 : req_op0;
        alu_a      <= grant_sel ? req_a1  : req_a0;
        alu_x      <= grant_sel ? req_b1  : req_b0;
        grant_q    <= grant_sel;
      end
      if (state == EXEC) begin
        rsp_data  <= alu_result;
        rsp_valid <= grant_q ? 2'b10 : 2'b01;
      end
      // Completion hands priority to the requester that was not just served.
      if (rsp_done) begin
        rsp_valid <= 2'b00;
        ops_done  <= ops_done + CNT_W'(1);
        ptr       <= ~grant_q;
      end
    end
  end

endmodule
